spart_mmio: RTL
===============

Name: spart_mmio

Overview:
- Memory-mapped UART peripheral on the shared CPU/bootloader bus. It is the upstream source of every byte the bootloader consumes and the sink for its banner character.
- Contains a serial RX engine and a serial TX engine, each with its own byte FIFO, behind three bus registers.
- The bus is a hold-until-ack protocol: the master holds read/write, address and data until it sees ack.
- Reads of an empty RX FIFO are stalled rather than failed.

Parameters:
- BASE_ADDR, 32'h0000001C, byte address of the TX data register. RX data is at BASE_ADDR+1; status is at BASE_ADDR+2.
- DIVISOR, 434, clk cycles per bit period. Must be ≥4.
- FIFO_DEPTH, 8, entries in each of the RX and TX FIFOs. Must be a power of two, ≥2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- bus_read  input  1  read request, held until ack
- bus_write  input  1  write request, held until ack
- bus_addr  input  32  request address
- bus_wdata  input  32  write data; only [7:0] is used
- bus_rdata  output  32  read data, valid in the ack cycle
- bus_ack  output  1  transaction complete this cycle
- uart_rxd  input  1  serial receive line, asynchronous
- uart_txd  output  1  serial transmit line

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. On reset:
  - both FIFOs empty, sticky flags cleared
  - RX and TX FSMs in IDLE
  - uart_txd=1, bus_ack=0, bus_rdata=0
  - rxd synchronizer flops set to 1
- Reset mid-frame aborts the frame; no partial byte is pushed.
- Bus decode (combinational; one-cycle transactions):
  - Write to BASE_ADDR: ack=1 iff TX FIFO not full; on ack, push wdata[7:0]. If full, ack stays 0 and the master stalls.
  - Read from BASE_ADDR+1: ack=1 iff RX FIFO not empty; rdata={24'b0, head}; pop at the clk edge. If empty, ack=0 and the master stalls.
  - Read from BASE_ADDR+2: ack=1 immediately; rdata={28'b0, frame_err, overrun, tx_not_full, rx_not_empty}. The sticky flags clear at the ack edge. An event in the same cycle wins, and its flag stays set.
  - Read of BASE_ADDR, or write of BASE_ADDR+1 / BASE_ADDR+2: ack=1, no effect, rdata=0.
  - Any other address: ack=0, rdata=0 (another slave responds).
  - bus_read and bus_write both high: ack=0, no effect.
  - rdata=0 whenever ack=0.
- RX FIFO:
  - Simultaneous push and pop is legal, including when full: no overrun, count unchanged.
  - Push while full and not popping: byte dropped, overrun set.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally; an extra count bit distinguishes full from empty.
- RX FSM (IDLE, START, DATA, STOP) on the 2-flop-synchronized rxd:
  - IDLE: a 1→0 edge loads the bit counter with DIVISOR/2-1 and goes to START.
  - START: at count expiry, sample. If 1, it is a false start → IDLE. If 0, reload DIVISOR-1 → DATA.
  - DATA: sample 8 bits, LSB first, one per DIVISOR cycles, shifting right.
  - STOP: sample. If 1, push the byte. If 0, drop it and set frame_err. Either way → IDLE, and the next edge is accepted immediately.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE: if the TX FIFO is not empty, pop into the shift register and go to START.
  - Each state lasts exactly DIVISOR cycles.
  - Line levels: txd=0 in START; LSB first in DATA; txd=1 in STOP.
  - After STOP, go to IDLE for 1 cycle, then start the next byte if one is queued. Gap between frames: 1 clk.
  - A bus push into an empty FIFO at the same edge as an IDLE check is seen the following cycle.
- Latency:
  - A byte is readable 1 cycle after its stop-bit sample.
  - TX start bit appears 2 cycles after the write ack (push edge, then IDLE pop edge).

Test Plan:
- TX banner: write 0x42 to 0x1C with DIVISOR=4 → ack in the same cycle; txd shows 0,0,1,0,0,0,0,1,0,1 (start, LSB first, stop), 4 clk per bit, then idles at 1.
- RX instruction-count stream: serially send 0x10,0x00,0x00,0x00, then hold bus_read at 0x1D → four consecutive ack cycles, rdata 0x10,0x00,0x00,0x00. A fifth read stalls (ack=0) until the next byte's stop sample, then acks with that byte.
- RX overrun: send 9 bytes 0x01..0x09 with no reads (DEPTH=8) → reads return 0x01..0x08. Status read returns bit2=1; a second status read returns bit2=0.
- Full plus simultaneous pop: FIFO full, bus pop coincides with the 9th byte's stop sample → no overrun; 8 entries remain; the last entry read is the new byte.
- Framing and false start:
  - Frame with stop=0 → no byte pushed; status bit3=1.
  - 1-cycle low glitch on rxd → no push, no error; the next valid frame 0xA5 is received correctly.
- Backpressure and reset: fill the TX FIFO (8 writes while transmitting), then a 9th write stalls until the first pop, then acks. Assert rst_n mid-frame → txd=1 immediately; FIFOs empty; status reads 0x2.

Source files
------------

// File: rtl/spart_mmio.sv
// spart_mmio: memory-mapped UART with RX/TX byte FIFOs behind TX-data, RX-data and status registers
module spart_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000001C,
  parameter int          DIVISOR    = 434,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_read,
  input  logic        bus_write,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  input  logic        uart_rxd,
  output logic        uart_txd
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DIVISOR);
  localparam logic [CW-1:0] DIV_M1 = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIVISOR / 2 - 1);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic [7:0] rx_mem [FIFO_DEPTH];
  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
  logic [AW:0] rx_cnt, tx_cnt;
  logic rx_full, rx_empty, tx_full, tx_empty;
  logic rd, wr, sel_tx, sel_rx, sel_st;
  logic tx_push, tx_pop, rx_push, rx_pop, rx_keep, st_ack, ovr_ev, fe_ev, rx_expire;
  logic overrun, frame_err;
  logic rxd_s1, rxd_s2, rxd_q;
  state_t rx_st, tx_st;
  logic [CW-1:0] rx_tmr, tx_tmr;
  logic [2:0] rx_bit, tx_bit;
  logic [7:0] rx_sh, tx_sh;
  logic unused_ok;
  assign rx_full = rx_cnt == FULL;
  assign rx_empty = rx_cnt == '0;
  assign tx_full = tx_cnt == FULL;
  assign tx_empty = tx_cnt == '0;
  assign rd = bus_read & ~bus_write;
  assign wr = bus_write & ~bus_read;
  assign sel_tx = bus_addr == BASE_ADDR;
  assign sel_rx = bus_addr == BASE_ADDR + 32'd1;
  assign sel_st = bus_addr == BASE_ADDR + 32'd2;
  assign tx_push = wr & sel_tx & ~tx_full;
  assign rx_pop = rd & sel_rx & ~rx_empty;
  assign st_ack = rd & sel_st;
  assign bus_ack = tx_push | rx_pop | st_ack | (rd & sel_tx) | (wr & (sel_rx | sel_st));
  assign bus_rdata = rx_pop ? {24'b0, rx_mem[rx_rp]} :
                     st_ack ? {28'b0, frame_err, overrun, ~tx_full, ~rx_empty} : 32'b0;
  assign tx_pop = (tx_st == IDLE) & ~tx_empty;
  assign rx_expire = (rx_st == STOP) & (rx_tmr == '0);
  assign rx_push = rx_expire & rxd_s2;
  assign fe_ev = rx_expire & ~rxd_s2;
  assign rx_keep = rx_push & (~rx_full | rx_pop);
  assign ovr_ev = rx_push & rx_full & ~rx_pop;
  assign unused_ok = ^bus_wdata[31:8];
  always_ff @(posedge clk) begin
    if (rx_keep) rx_mem[rx_wp] <= rx_sh;
    if (tx_push) tx_mem[tx_wp] <= bus_wdata[7:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_wp <= '0;
      rx_rp <= '0;
      rx_cnt <= '0;
      tx_wp <= '0;
      tx_rp <= '0;
      tx_cnt <= '0;
      overrun <= 1'b0;
      frame_err <= 1'b0;
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
      rxd_q <= 1'b1;
    end else begin
      if (rx_keep) rx_wp <= rx_wp + 1'b1;
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
      rx_cnt <= rx_cnt + (AW+1)'(rx_keep) - (AW+1)'(rx_pop);
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop) tx_rp <= tx_rp + 1'b1;
      tx_cnt <= tx_cnt + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
      overrun <= ovr_ev | (overrun & ~st_ack);
      frame_err <= fe_ev | (frame_err & ~st_ack);
      rxd_s1 <= uart_rxd;
      rxd_s2 <= rxd_s1;
      rxd_q <= rxd_s2;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_st <= IDLE;
      rx_tmr <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
    end else begin
      case (rx_st)
        IDLE: if (rxd_q & ~rxd_s2) begin
          rx_tmr <= HALF_M1;
          rx_st <= START;
        end
        START: if (rx_tmr != '0) rx_tmr <= rx_tmr - 1'b1;
          else if (rxd_s2) rx_st <= IDLE;
          else begin
            rx_tmr <= DIV_M1;
            rx_bit <= '0;
            rx_st <= DATA;
          end
        DATA: if (rx_tmr != '0) rx_tmr <= rx_tmr - 1'b1;
          else begin
            rx_sh <= {rxd_s2, rx_sh[7:1]};
            rx_tmr <= DIV_M1;
            rx_bit <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_st <= STOP;
          end
        STOP: if (rx_tmr != '0) rx_tmr <= rx_tmr - 1'b1;
          else rx_st <= IDLE;
        default: rx_st <= IDLE;
      endcase
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_st <= IDLE;
      tx_tmr <= '0;
      tx_bit <= '0;
      tx_sh <= '0;
      uart_txd <= 1'b1;
    end else begin
      case (tx_st)
        IDLE: if (tx_pop) begin
          tx_sh <= tx_mem[tx_rp];
          tx_tmr <= DIV_M1;
          uart_txd <= 1'b0;
          tx_st <= START;
        end
        START: if (tx_tmr != '0) tx_tmr <= tx_tmr - 1'b1;
          else begin
            uart_txd <= tx_sh[0];
            tx_sh <= tx_sh >> 1;
            tx_tmr <= DIV_M1;
            tx_bit <= '0;
            tx_st <= DATA;
          end
        DATA: if (tx_tmr != '0) tx_tmr <= tx_tmr - 1'b1;
          else begin
            uart_txd <= (tx_bit == 3'd7) | tx_sh[0];
            tx_sh <= tx_sh >> 1;
            tx_tmr <= DIV_M1;
            tx_bit <= tx_bit + 1'b1;
            if (tx_bit == 3'd7) tx_st <= STOP;
          end
        STOP: if (tx_tmr != '0) tx_tmr <= tx_tmr - 1'b1;
          else tx_st <= IDLE;
        default: tx_st <= IDLE;
      endcase
    end
endmodule
